seq_alu: RTL
============

Name: seq_alu

Overview:
- Registered, handshaked successor to the lab ALU, parametrised in data width.
- Keeps the 16-op 4-bit function set.
- Shift ops take a variable amount from B and run iteratively, one bit per cycle.
- Adds TCP/ALS overflow detection and a sticky overflow flag.
- Sits between operand issue logic and the writeback register; one operation in flight.

Parameters:
DATA_WIDTH, 16, operand/result width (>=4, power of two)
SHAMT_W, $clog2(DATA_WIDTH), width of shift-amount field taken from b[SHAMT_W-1:0]

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands/func presented
in_ready  output  1  block can accept operation this cycle
func  input  4  operation code
a  input  DATA_WIDTH  operand A
b  input  DATA_WIDTH  operand B (shift amount for shift ops)
out_valid  output  1  c/ovf hold a result
out_ready  input  1  consumer accepts result
c  output  DATA_WIDTH  result
ovf  output  1  overflow for the current result
sticky_ovf  output  1  OR of ovf of every result consumed since reset/clear
clr_sticky  input  1  clears sticky_ovf
busy  output  1  state != IDLE

Behaviour:
- Encoding, decided:
  - ADD 0000, SUB 0001, ID 0010, NOT 0011, AND 0100, OR 0101, NAND 0110, NOR 0111.
  - XOR 1000, XNOR 1001, LLS 1010, LRS 1011, ALS 1100, ARS 1101, TCP 1110, ZERO 1111.
- Reset (sync): state=IDLE, c=0, ovf=0, out_valid=0, sticky_ovf=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch func/a/b.
    - Non-shift op: compute, register c/ovf, go DONE.
    - Shift op with amount n=0: c=a, ovf=0, go DONE.
    - Shift op with n>0: load a into the working register, cnt=n, go SHIFT.
  - SHIFT: each cycle shift the working register by 1, cnt--. When cnt reaches 0, result goes to c and state goes to DONE.
  - DONE: out_valid=1, c/ovf stable.
    - out_ready=1: result consumed.
    - If in_valid is also high: accept the new op the same cycle (in_ready=out_ready in DONE, combinational).
    - If in_valid is low: go IDLE.
- Latency from the accept edge to out_valid:
  - 1 cycle for non-shift ops and for n=0.
  - 1+n cycles for shifts; maximum 1+(DATA_WIDTH-1).
- Arithmetic: all results mod 2^DATA_WIDTH.
  - ADD ovf: signs of a,b equal and differ from the sign of c.
  - SUB ovf: signs of a,b differ and the sign of c differs from a.
  - TCP: c=~a+1; ovf=1 iff a = 1 followed by zeros (most negative).
  - ALS: zero fill. ovf=1 if the MSB changes at any step of the shift.
  - LLS: zero fill.
  - LRS: zero fill from MSB.
  - ARS: sign fill.
  - All other ops: ovf=0.
- Sticky overflow:
  - On the edge where out_valid&&out_ready, sticky_ovf |= ovf.
  - clr_sticky forces 0 and has priority over a simultaneous set.
- Inputs are ignored while busy except in DONE with out_ready=1. Inputs are sampled only at the accept edge; later changes to a/b/func do not affect an op in flight.
- Back-pressure: DONE holds indefinitely while out_ready=0, with no change on c.
- Reset mid-SHIFT or mid-DONE: the op is discarded; no result and no sticky update.
- Undefined/X func is not possible (4-bit full decode).

Test Plan:
1. ADD a=16'h7FFF b=16'h0001, out_ready=1 -> out_valid 1 cycle after accept, c=16'h8000, ovf=1, then sticky_ovf=1.
2. LRS a=16'h8000 b=16'h0004 -> out_valid exactly 5 cycles after accept, c=16'h0800, ovf=0, busy high for 5 cycles. Repeat with ARS -> c=16'hF800.
3. ALS a=16'h2001 b=3 -> c=16'h0008, ovf=1 (MSB changed at step 2). TCP a=16'h8000 -> c=16'h8000, ovf=1.
4. Back-to-back SUB ops with out_ready=1 and in_valid=1 held -> one result per cycle. SUB 16'h8000-16'h0001 -> c=16'h7FFF, ovf=1.
5. Hold out_ready=0 for 10 cycles after XOR a=16'hF0F0 b=16'h0FF0 -> c stays 16'hFF00, in_ready=0. Release -> consumed, IDLE.
6. Reset asserted mid-shift (LLS, b=8, cycle 3) -> next cycle out_valid=0, c=0, state IDLE. clr_sticky with a simultaneous overflow consume -> sticky_ovf=0.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked ALU with the 16-op function set.
// Shift ops run one bit per cycle. Overflow is detected for ADD, SUB, TCP and ALS.
// sticky_ovf accumulates the overflow flag of every consumed result.
module seq_alu #(
  parameter int DATA_WIDTH = 16,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            func,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] c,
  output logic                  ovf,
  output logic                  sticky_ovf,
  input  logic                  clr_sticky,
  output logic                  busy
);

  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ID   = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_LLS  = 4'b1010;
  localparam logic [3:0] OP_LRS  = 4'b1011;
  localparam logic [3:0] OP_ALS  = 4'b1100;
  localparam logic [3:0] OP_ARS  = 4'b1101;
  localparam logic [3:0] OP_TCP  = 4'b1110;
  localparam logic [3:0] OP_ZERO = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT                 stateReg;
  logic [DATA_WIDTH-1:0] cReg;
  logic                  ovfReg;
  logic                  outValidReg;
  logic                  stickyReg;
  logic [DATA_WIDTH-1:0] workReg;
  logic [SHAMT_W-1:0]    cntReg;
  logic [3:0]            shOpReg;
  logic                  shOvfReg;

  logic                  accept;
  logic                  isShift;
  logic [SHAMT_W-1:0]    shAmt;
  logic [DATA_WIDTH:0]   aluRes;
  logic [DATA_WIDTH-1:0] stepVal;
  logic                  stepOvf;

  // Single-cycle (non-shift) operations; returns {ovf, result}.
  function automatic logic [DATA_WIDTH:0] aluOp(input logic [3:0] op,
                                                input logic [DATA_WIDTH-1:0] x,
                                                input logic [DATA_WIDTH-1:0] y);
    logic [DATA_WIDTH-1:0] r;
    logic                  o;
    r = {DATA_WIDTH{1'b0}};
    o = 1'b0;
    case (op)
      OP_ADD: begin
        r = x + y;
        o = (x[MSB] == y[MSB]) && (r[MSB] != x[MSB]);
      end
      OP_SUB: begin
        r = x - y;
        o = (x[MSB] != y[MSB]) && (r[MSB] != x[MSB]);
      end
      OP_ID:   r = x;
      OP_NOT:  r = ~x;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      OP_XNOR: r = ~(x ^ y);
      OP_TCP: begin
        r = ~x + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        o = (x == {1'b1, {(DATA_WIDTH-1){1'b0}}});
      end
      OP_ZERO: r = {DATA_WIDTH{1'b0}};
      default: begin
        r = {DATA_WIDTH{1'b0}};
        o = 1'b0;
      end
    endcase
    return {o, r};
  endfunction

  // One-bit shift step of the working register.
  function automatic logic [DATA_WIDTH-1:0] shiftStep(input logic [3:0] op,
                                                      input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_LLS, OP_ALS: r = {w[MSB-1:0], 1'b0};
      OP_LRS:         r = {1'b0, w[MSB:1]};
      OP_ARS:         r = {w[MSB], w[MSB:1]};
      default:        r = w;
    endcase
    return r;
  endfunction

  // Handshake decode, operation classification and shift-step datapath.
  always_comb begin
    in_ready = 1'b0;
    if (stateReg == IDLE) begin
      in_ready = 1'b1;
    end else if (stateReg == DONE) begin
      in_ready = out_ready;
    end else begin
      in_ready = 1'b0;
    end
    accept  = in_valid && in_ready;
    isShift = (func == OP_LLS) || (func == OP_LRS) || (func == OP_ALS) || (func == OP_ARS);
    shAmt   = b[SHAMT_W-1:0];
    aluRes  = aluOp(func, a, b);
    stepVal = shiftStep(shOpReg, workReg);
    stepOvf = (shOpReg == OP_ALS) && (stepVal[MSB] != workReg[MSB]);
  end

  // Control FSM, result registers and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= IDLE;
      cReg        <= {DATA_WIDTH{1'b0}};
      ovfReg      <= 1'b0;
      outValidReg <= 1'b0;
      stickyReg   <= 1'b0;
      workReg     <= {DATA_WIDTH{1'b0}};
      cntReg      <= {SHAMT_W{1'b0}};
      shOpReg     <= 4'b0000;
      shOvfReg    <= 1'b0;
    end else begin
      // clear wins over a simultaneous consume of an overflowing result
      if (clr_sticky) begin
        stickyReg <= 1'b0;
      end else if (outValidReg && out_ready) begin
        stickyReg <= stickyReg | ovfReg;
      end else begin
        stickyReg <= stickyReg;
      end

      if (accept) begin
        if (!isShift) begin
          cReg        <= aluRes[DATA_WIDTH-1:0];
          ovfReg      <= aluRes[DATA_WIDTH];
          outValidReg <= 1'b1;
          stateReg    <= DONE;
        end else if (shAmt == {SHAMT_W{1'b0}}) begin
          cReg        <= a;
          ovfReg      <= 1'b0;
          outValidReg <= 1'b1;
          stateReg    <= DONE;
        end else begin
          workReg     <= a;
          cntReg      <= shAmt;
          shOpReg     <= func;
          shOvfReg    <= 1'b0;
          outValidReg <= 1'b0;
          stateReg    <= SHIFT;
        end
      end else begin
        case (stateReg)
          SHIFT: begin
            if (cntReg == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
              cReg        <= stepVal;
              ovfReg      <= shOvfReg | stepOvf;
              outValidReg <= 1'b1;
              stateReg    <= DONE;
            end else begin
              workReg  <= stepVal;
              cntReg   <= cntReg - {{(SHAMT_W-1){1'b0}}, 1'b1};
              shOvfReg <= shOvfReg | stepOvf;
            end
          end
          DONE: begin
            if (out_ready) begin
              outValidReg <= 1'b0;
              stateReg    <= IDLE;
            end else begin
              stateReg <= DONE;
            end
          end
          default: stateReg <= IDLE;
        endcase
      end
    end
  end

  assign c          = cReg;
  assign ovf        = ovfReg;
  assign out_valid  = outValidReg;
  assign sticky_ovf = stickyReg;
  assign busy       = (stateReg != IDLE);

endmodule
